// File: rtl/mem_copy_dma.sv
// Purpose : single-channel block copy / block fill engine driving a single-cycle word RAM port.
// Latency : copy of N words = 2N busy cycles + 1 done cycle; fill = N busy + 1 done; rejected or empty = 1 done cycle.
// Backpres: none; start is sampled only in IDLE and ignored while busy or in DONE (no queueing).
// Ports   : clk/rst_n (async active-low); start/mode/src_addr/dst_addr/len/fill_val request inputs;
//           busy/done/err status; mem_a/mem_wd/mem_we RAM initiator outputs, mem_rd combinational read data.
module mem_copy_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_val,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  output logic             mem_we,
  input  logic [31:0]      mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] count;
  logic             mode_q;
  logic [31:0]      fill_q;
  logic [31:0]      data_q;

  // Source alignment only matters for copies; a fill never reads.
  logic bad_align;
  assign bad_align = (dst_addr[1:0] != 2'b00) || (!mode && (src_addr[1:0] != 2'b00));

  logic last_word;
  assign last_word = (count == {{(LEN_W-1){1'b0}}, 1'b1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // RAM-side outputs depend only on state and registers, never on start or mem_rd.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_a    = 32'h0;
    mem_wd   = 32'h0;
    mem_we   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (bad_align || (len == '0)) begin
            state_nx = S_DONE;
          end else if (mode) begin
            state_nx = S_WRITE;
          end else begin
            state_nx = S_READ;
          end
        end
      end
      S_READ: begin
        busy     = 1'b1;
        mem_a    = src_ptr;
        state_nx = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        mem_a  = dst_ptr;
        mem_wd = mode_q ? fill_q : data_q;
        mem_we = 1'b1;
        if (last_word) begin
          state_nx = S_DONE;
        end else if (mode_q) begin
          state_nx = S_WRITE;
        end else begin
          state_nx = S_READ;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr <= 32'h0;
      dst_ptr <= 32'h0;
      count   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= 32'h0;
      data_q  <= 32'h0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            count   <= len;
            mode_q  <= mode;
            fill_q  <= fill_val;
            // err reflects only the most recently accepted request.
            err     <= bad_align;
          end
        end
        S_READ: begin
          data_q  <= mem_rd;
          src_ptr <= src_ptr + 32'd4;
        end
        S_WRITE: begin
          dst_ptr <= dst_ptr + 32'd4;
          count   <= count - {{(LEN_W-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Purpose : self-checking bench for mem_copy_dma with a 256-word RAM (indexed by mem_a[9:2]).
// Latency : expectations come from a word-level model of each transfer plus fixed timing rules.
// Backpres: none; every wait on the DUT is bounded by a cycle budget.
module tb_mem_copy_dma;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic [31:0] fill_val;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] ram  [256];
  logic [31:0] mram [256];
  logic        tb_we;
  logic [7:0]  tb_a;
  logic [31:0] tb_wd;

  int checks;
  int errors;

  mem_copy_dma #(.LEN_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .fill_val (fill_val),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: combinational read, write on rising edge; bench preload port when DUT is not writing.
  assign mem_rd = ram[mem_a[9:2]];
  always @(posedge clk) begin
    if (mem_we) ram[mem_a[9:2]] <= mem_wd;
    else if (tb_we) ram[tb_a] <= tb_wd;
  end

  task automatic chk_eq(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (case %0d): got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  task automatic poke_ram(input int i, input logic [31:0] v);
    @(negedge clk);
    tb_we = 1'b1;
    tb_a  = i[7:0];
    tb_wd = v;
    @(posedge clk);
    #1 tb_we = 1'b0;
    mram[i] = v;
  endtask

  task automatic chk_ram(input int id);
    int bad;
    bad = -1;
    for (int i = 0; i < 256; i++) if (bad < 0 && ram[i] !== mram[i]) bad = i;
    if (bad < 0) chk_eq("ram", id, {32'h0, ram[0]}, {32'h0, mram[0]});
    else chk_eq($sformatf("ram[%0d]", bad), id, {32'h0, ram[bad]}, {32'h0, mram[bad]});
  endtask

  // Word-level reference: ascending word moves over the model RAM, timing from the transfer rules.
  task automatic model(input bit md, input logic [31:0] s, input logic [31:0] d, input int n,
                       input logic [31:0] f, output bit e_err, output int e_busy,
                       output int e_done, output int e_we);
    logic [31:0] sa, da, w;
    e_err = (d[1:0] != 2'b00) || (!md && s[1:0] != 2'b00);
    if (e_err || n == 0) begin
      e_busy = 0; e_done = 1; e_we = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        sa = s + 32'(4 * i);
        da = d + 32'(4 * i);
        w  = md ? f : mram[sa[9:2]];
        mram[da[9:2]] = w;
      end
      e_busy = md ? n : 2 * n;
      e_done = e_busy + 1;
      e_we   = n;
    end
  endtask

  task automatic run_xfer(input bit md, input logic [31:0] s, input logic [31:0] d, input int n,
                          input logic [31:0] f, input int poke, input bit e_err, input int e_busy,
                          input int e_done, input int e_we, input int id);
    int bcnt, wcnt, dcyc;
    bcnt = 0; wcnt = 0; dcyc = 0;
    @(negedge clk);
    mode = md; src_addr = s; dst_addr = d; len = n[15:0]; fill_val = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 2 * n + 8 && dcyc == 0; cyc++) begin
      @(negedge clk);
      // A start pulse here must be ignored (busy or DONE).
      if (poke == cyc) begin
        start = 1'b1; mode = 1'b1; dst_addr = 32'h300; fill_val = 32'hBAD0BAD0;
      end else begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (mem_we) wcnt++;
      if (done) begin
        dcyc = cyc;
        chk_eq("done_outputs", id, {31'h0, busy, mem_we, mem_a}, 64'h0);
        chk_eq("err", id, {63'h0, err}, {63'h0, e_err});
      end
    end
    start = 1'b0;
    chk_eq("done_cycle", id, 64'(dcyc), 64'(e_done));
    chk_eq("busy_cycles", id, 64'(bcnt), 64'(e_busy));
    chk_eq("we_pulses", id, 64'(wcnt), 64'(e_we));
    chk_ram(id);
  endtask

  typedef struct {
    bit          md;
    logic [31:0] s;
    logic [31:0] d;
    int          n;
    logic [31:0] f;
    int          poke;
    bit          e_err;
    int          e_busy;
    int          e_done;
    int          e_we;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit   m_err;
    int   m_busy, m_done, m_we;
    bit   md;
    logic [31:0] s, d, f;
    int   n, wcnt;

    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h0;
    len = 16'h0; fill_val = 32'h0; tb_we = 1'b0; tb_a = 8'h0; tb_wd = 32'h0;

    // Fixed expectations for the directed cases.
    vecs[0] = '{1'b0, 32'h0,   32'h100, 4, 32'h0,        0, 1'b0, 8, 9, 4};
    vecs[1] = '{1'b1, 32'h0,   32'h20,  3, 32'hDEADBEEF, 0, 1'b0, 3, 4, 3};
    vecs[2] = '{1'b0, 32'h0,   32'h100, 0, 32'h0,        0, 1'b0, 0, 1, 0};
    vecs[3] = '{1'b1, 32'h0,   32'h102, 3, 32'h12345678, 0, 1'b1, 0, 1, 0};
    vecs[4] = '{1'b1, 32'h0,   32'h40,  1, 32'h00000005, 2, 1'b0, 1, 2, 1};
    vecs[5] = '{1'b0, 32'h1,   32'h200, 2, 32'h0,        0, 1'b1, 0, 1, 0};
    vecs[6] = '{1'b1, 32'h3,   32'h200, 2, 32'h00000007, 0, 1'b0, 2, 3, 2};

    #1;
    chk_eq("reset_outputs", -1, {28'h0, busy, done, err, mem_we, mem_a}, 64'h0);
    chk_eq("reset_wd", -1, {32'h0, mem_wd}, 64'h0);

    for (int i = 0; i < 256; i++) poke_ram(i, $urandom);
    poke_ram(0, 32'h11); poke_ram(1, 32'h22); poke_ram(2, 32'h33); poke_ram(3, 32'h44);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      model(vecs[i].md, vecs[i].s, vecs[i].d, vecs[i].n, vecs[i].f, m_err, m_busy, m_done, m_we);
      run_xfer(vecs[i].md, vecs[i].s, vecs[i].d, vecs[i].n, vecs[i].f, vecs[i].poke,
               vecs[i].e_err, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_we, i);
    end
    chk_eq("copy_dst0", 10, {32'h0, ram[8'h40]}, 64'h11);
    chk_eq("copy_dst3", 10, {32'h0, ram[8'h43]}, 64'h44);
    chk_eq("fill_untouched", 11, {32'h0, ram[11]}, {32'h0, mram[11]});

    // Reset in the middle of a 4-word copy, right after the second write.
    @(negedge clk);
    mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h180; len = 16'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wcnt = 0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (mem_we) wcnt++;
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_eq("midreset_outputs", 20, {28'h0, busy, done, err, mem_we, mem_a}, 64'h0);
    chk_eq("midreset_wd", 20, {32'h0, mem_wd}, 64'h0);
    chk_eq("midreset_writes", 20, 64'(wcnt), 64'd2);
    mram[8'h60] = mram[0];
    mram[8'h61] = mram[1];
    chk_ram(20);
    @(negedge clk);
    rst_n = 1'b1;
    model(1'b0, 32'h0, 32'h180, 4, 32'h0, m_err, m_busy, m_done, m_we);
    run_xfer(1'b0, 32'h0, 32'h180, 4, 32'h0, 0, 1'b0, 8, 9, 4, 21);

    // Overlapping copy, with a start pulse while busy.
    poke_ram(0, 32'h1); poke_ram(1, 32'h2); poke_ram(2, 32'h3);
    model(1'b0, 32'h0, 32'h4, 2, 32'h0, m_err, m_busy, m_done, m_we);
    run_xfer(1'b0, 32'h0, 32'h4, 2, 32'h0, 2, 1'b0, 4, 5, 2, 30);
    chk_eq("overlap_w1", 30, {32'h0, ram[1]}, 64'h1);
    chk_eq("overlap_w2", 30, {32'h0, ram[2]}, 64'h1);

    // Destination pointer wraps through zero.
    model(1'b1, 32'h0, 32'hFFFF_FFFC, 2, 32'hA5A5_5A5A, m_err, m_busy, m_done, m_we);
    run_xfer(1'b1, 32'h0, 32'hFFFF_FFFC, 2, 32'hA5A5_5A5A, 0, 1'b0, 2, 3, 2, 40);
    chk_eq("wrap_top", 40, {32'h0, ram[255]}, 64'hA5A5_5A5A);
    chk_eq("wrap_zero", 40, {32'h0, ram[0]}, 64'hA5A5_5A5A);

    // Randomized transfers against the model.
    for (int i = 0; i < 40; i++) begin
      md = 1'($urandom_range(0, 1));
      s  = $urandom;
      d  = $urandom;
      if ($urandom_range(0, 7) != 0) s[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) d[1:0] = 2'b00;
      n  = $urandom_range(0, 12);
      f  = $urandom;
      model(md, s, d, n, f, m_err, m_busy, m_done, m_we);
      run_xfer(md, s, d, n, f, 0, m_err, m_busy, m_done, m_we, 100 + i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Single-channel block-transfer engine that acts as the initiator on the single-cycle word RAM port: it drives address, write data and write enable, and samples combinational read data. Firmware-visible control (or a test harness) programs source, destination, length and mode, pulses start, and the engine copies a word block or fills it with a constant, then pulses done. It sits beside the CPU data port on the RAM interface and is used for memory initialisation and block moves.

## Interface
- LEN_W, 16, width of the word-count field; maximum transfer 2^LEN_W-1 words
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = copy src→dst, 1 = fill dst with fill_val
- src_addr  in  32  byte address of first source word (copy mode)
- dst_addr  in  32  byte address of first destination word
- len  in  LEN_W  transfer length in 32-bit words
- fill_val  in  32  fill pattern (fill mode)
- busy  out  1  transfer in progress (READ or WRITE state)
- done  out  1  one-cycle completion pulse
- err  out  1  last accepted request was rejected (unaligned address)
- mem_a  out  32  RAM byte address
- mem_wd  out  32  RAM write data
- mem_we  out  1  RAM write enable (RAM writes on rising clk)
- mem_rd  in  32  RAM read data, combinational from mem_a

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: mem_a=0, mem_wd=0, mem_we=0, busy=0, done=0. On clk edge with start=1: latch mode, src_addr, dst_addr, len, fill_val into src_ptr, dst_ptr, count, mode_q, fill_q; clear err.
  - If src_addr[1:0]≠0 (copy mode only) or dst_addr[1:0]≠0: set err=1, go DONE; no RAM access.
  - Else if len=0: go DONE, err=0, no RAM access.
  - Else mode=0 → READ; mode=1 → WRITE.
- READ: mem_a=src_ptr, mem_we=0; at edge latch data_q←mem_rd, src_ptr←src_ptr+4, go WRITE.
- WRITE: mem_a=dst_ptr, mem_wd = mode_q ? fill_q : data_q, mem_we=1; at edge dst_ptr←dst_ptr+4, count←count-1. If count was 1 → DONE; else copy → READ, fill → WRITE.
- DONE: done=1 for exactly one cycle, busy=0, mem_we=0, mem_a=0; next state IDLE. start ignored here.
- Pointer arithmetic is modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000); no boundary check.
- Copy order is strictly ascending; overlapping regions with dst>src read already-written words (defined, not corrected).
- err holds its value until the next accepted start.
- start while busy or in DONE is ignored; no queueing.

## Timing
- Reset (rst_n low, any time, including mid-transfer): state=IDLE, busy=0, done=0, err=0, mem_a=0, mem_wd=0, mem_we=0, all internal registers 0; immediate (asynchronous). A partially completed block is left in RAM as-is.
- Copy of N words: busy high 2N cycles beginning the cycle after the start edge; N writes, one every second cycle; done high in cycle 2N+1 after the start edge.
- Fill of N words: busy high N cycles, one write per cycle, done in cycle N+1.
- len=0 or err: busy never asserts; done high in the cycle immediately after the start edge.
- Next start accepted in the cycle after done (IDLE).
- mem_a/mem_wd/mem_we are pure functions of state and registers (no combinational path from start or mem_rd to outputs).

## Test plan
- Copy: RAM[0..3]=0x11,0x22,0x33,0x44; src=0x0, dst=0x100, len=4, mode=0 -> RAM[0x40..0x43]=0x11..0x44, busy 8 cycles, done in cycle 9, 4 we pulses, source unchanged.
- Fill: dst=0x20, len=3, fill_val=0xDEADBEEF, mode=1 -> RAM[8..10]=0xDEADBEEF, RAM[11] untouched, busy 3 cycles, done in cycle 4.
- Boundaries: len=0 -> done next cycle, no we, err=0; dst=0x102 -> done next cycle, err=1, no we; following valid start clears err.
- Overlap/ignore: RAM[0..2]=1,2,3, src=0, dst=4, len=2 -> RAM[1]=1, RAM[2]=1; start pulsed mid-transfer has no effect.
- Reset mid-copy: assert rst_n=0 after second write of a len=4 copy -> all outputs 0 immediately, RAM shows exactly 2 copied words, fresh start after release runs normally.
- Wrap: fill dst=0xFFFF_FFFC (model only low bits), len=2 -> writes at 0xFFFF_FFFC then 0x0000_0000.
